// File: rtl/jtvigil_gfx_slot.sv
// jtvigil_gfx_slot: one-entry cached SDRAM read slot that builds 32-bit words from two 16-bit beats.
// Optional watchdog: define JTVIGIL_SLOT_TIMEOUT_EN to abandon stalled fetches with a zero word.
module jtvigil_gfx_slot #(
    parameter int          AW     = 18,
    parameter logic [21:0] OFFSET = 22'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic [31:0]   data,
    output logic          ok,
    output logic [21:0]   sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          data_dst,
    input  logic [15:0]   sdram_din
);
    typedef enum logic [1:0] {IDLE, REQ, BEAT0, BEAT1} state_t;

    state_t        st, st_nx;
    logic          valid;
    logic [AW-1:0] tag;
    logic [AW-1:0] fetch_addr;
    logic [15:0]   stage;
    logic          hit;
    logic          timeout;

    assign hit = valid && tag == addr;
    assign ok  = cs && hit;

`ifdef JTVIGIL_SLOT_TIMEOUT_EN
    logic [7:0] wdog;
    assign timeout = st != IDLE && wdog == 8'hFF;
    always_ff @(posedge clk) begin
        if (!rst_n || st == IDLE || st_nx != st)
            wdog <= 8'd0;
        else
            wdog <= wdog + 8'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            st <= IDLE;
        else
            st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    st_nx = cs && !hit ? REQ : IDLE;
            REQ:     st_nx = sdram_ack ? BEAT0 : REQ;
            BEAT0:   st_nx = data_dst ? BEAT1 : BEAT0;
            BEAT1:   st_nx = data_dst ? IDLE : BEAT1;
            default: st_nx = IDLE;
        endcase
        if (timeout) st_nx = IDLE;
    end

    // The cache entry only changes on the final beat, so old hits stay servable during a fill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sdram_req  <= 1'b0;
            sdram_addr <= 22'd0;
            data       <= 32'd0;
            valid      <= 1'b0;
            tag        <= '0;
            fetch_addr <= '0;
            stage      <= 16'd0;
        end else if (timeout) begin
            sdram_req <= 1'b0;
            data      <= 32'd0;
            tag       <= fetch_addr;
            valid     <= 1'b1;
        end else begin
            case (st)
                IDLE: if (cs && !hit) begin
                    fetch_addr <= addr;
                    sdram_addr <= OFFSET + 22'({addr, 1'b0});
                    sdram_req  <= 1'b1;
                end
                REQ:   if (sdram_ack) sdram_req <= 1'b0;
                BEAT0: if (data_dst) stage <= sdram_din;
                BEAT1: if (data_dst) begin
                    data  <= {sdram_din, stage};
                    tag   <= fetch_addr;
                    valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/jtvigil_gfx_slot.md
# jtvigil_gfx_slot

Single-client SDRAM read slot that serves one video graphics fetcher: the scroll 1, scroll 2 or object layer. It takes the client's `cs`/`addr` request and returns 32-bit `data` with `ok`. It sits between a layer's ROM port and the SDRAM controller. It holds a one-entry cache and assembles each 32-bit word from two 16-bit SDRAM beats.

## Interface
Parameters:
- `AW`, 18: client address width; addresses 32-bit words.
- `OFFSET`, 22'h0: SDRAM base, in 16-bit word units, added to the client address.

Ports:
- `clk`  in  1  system clock (48 MHz); the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `cs`  in  1  client request.
- `addr`  in  AW  client word address.
- `data`  out  32  cached word.
- `ok`  out  1  `data` is valid for the current `addr`.
- `sdram_addr`  out  22  SDRAM word address = `OFFSET + {addr,1'b0}` latched at request.
- `sdram_req`  out  1  read request, held until `sdram_ack`.
- `sdram_ack`  in  1  one-cycle request accept.
- `data_dst`  in  1  a beat for this slot is on `sdram_din`.
- `sdram_din`  in  16  SDRAM read data.

## Operation
- Cache: `valid` (1 bit), `tag` (AW bits), `data` (32 bits).
- `ok = cs & valid & (tag == addr)`. This is combinational from registers and inputs, so a hit has zero added latency.
- FSM states: IDLE, REQ, BEAT0, BEAT1.
- IDLE:
  - On `cs & ~hit`: latch `addr` into `fetch_addr` and drive `sdram_addr`.
  - Set `sdram_req` and go to REQ.
- REQ: hold `sdram_req` and `sdram_addr`. On `sdram_ack`, clear `sdram_req` and go to BEAT0.
- BEAT0: on `data_dst`, store `sdram_din` as `data[15:0]` in a staging register and go to BEAT1. The low halfword comes first.
- BEAT1: on `data_dst`:
  - Write `{sdram_din, stage}` into `data`.
  - Load `tag <= fetch_addr` and set `valid <= 1`.
  - Go to IDLE.
- `data_dst` outside BEAT0/BEAT1 is ignored.
- If `addr` changes or `cs` falls mid-fetch, there is no abort. The fetch completes and fills the cache with `fetch_addr`. If the new `addr` misses, a new request starts the cycle after the return to IDLE.
- `sdram_addr` arithmetic: 22-bit modulo sum; overflow wraps silently.
- While a fill is in progress, `data` keeps the old entry. `ok` stays consistent with `tag`, so an old hit remains servable until the BEAT1 write.

## Timing
- Reset values:
  - Outputs: `sdram_req=0`, `sdram_addr=0`, `data=0`, `ok=0`.
  - Internal: `valid=0`, `tag=0`, state IDLE.
- Reset mid-fetch returns to IDLE on the next edge and drops `sdram_req`. Late beats are ignored.
- Miss path, with T0 as the first edge seeing `cs` with a miss:
  - `sdram_req` high after T0.
  - If ack arrives at T0+k, then BEAT0 follows.
  - `ok` rises the cycle after the edge that samples the second `data_dst`.
  - Minimum miss-to-`ok` is 4 edges when ack and beats arrive back-to-back.
- `sdram_ack` and `data_dst` in the same cycle while in REQ: the ack is taken and the beat is ignored. The controller must not do this.
- A new request cannot issue in the same cycle as the BEAT1 write.

## Configuration
- `JTVIGIL_SLOT_TIMEOUT_EN` defined:
  - An 8-bit watchdog counts cycles in REQ/BEAT0/BEAT1 and clears on every state change.
  - At count 255, the FSM forces IDLE and drops `sdram_req`.
  - It writes `data=32'h0` with `tag=fetch_addr` and `valid=1`, so the client unblocks with a zero pixel.
- Undefined: no counter; the FSM waits indefinitely.

## Test plan
- Reset, then `cs=1`, `addr=18'h00010`, `OFFSET=0` -> `sdram_req=1`, `sdram_addr=22'h000020`. After ack, send beats 16'h3412 then 16'h7856 -> `data=32'h78563412`, `ok=1` one cycle after the second beat.
- Same `addr` held after fill -> `ok=1` every cycle, no new `sdram_req`. Change `addr` to 18'h00011 -> `ok=0` immediately and a request with `sdram_addr=22'h000022`.
- `addr` changes from 18'h5 to 18'h6 between ack and BEAT0 -> the cache fills with tag 5, then a second request to 22'h00000C follows; `ok` rises only after the second fill.
- `rst_n=0` for one cycle during BEAT1 -> `sdram_req=0`, `ok=0`. A stray `data_dst` after reset leaves `valid=0`.
- `OFFSET=22'h3FFFFE`, `addr=1` -> `sdram_addr=22'h000000` (wrap).
- With `JTVIGIL_SLOT_TIMEOUT_EN`, never assert ack -> after 255 cycles `sdram_req=0`, `data=0`, `ok=1`. Without the macro, the bench checks that `sdram_req` is still high after 1000 cycles.
